ram_array_dp: RTL

Parametrised synchronous RAM for the toy processor: one write port, two independent registered read ports, and a built-in clear sequencer that fills every word with a fixed value after reset or on request. It is the data/register store behind the datapath, and it generalises the fixed 8x256 single-port array. While clearing, it raises `BUSY` and ignores all other traffic.

---
 rtl/ram_array_pkg.sv | 12 +
 rtl/ram_clear_seq.sv | 56 +++++
 rtl/ram_array_dp.sv | 80 ++++++++
 3 files changed

// File: rtl/ram_array_pkg.sv
// Shared types and default sizes for the dual-read-port RAM and its clear sequencer.
package ram_array_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 8;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every address once after reset or a clear request, then hands
// the array back to the user port. State is exposed for observation by the top level.
module ram_clear_seq
    import ram_array_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  busy,
    output ram_state_e            state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [ADDR_WIDTH-1:0] cnt;

    // The counter stops at the last address instead of wrapping; the state change ends the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
                READY: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    assign clear_we   = (state == CLEAR);
    assign clear_addr = cnt;

endmodule

// File: rtl/ram_array_dp.sv
// One-write, two-read synchronous RAM with a built-in clear sweep.
// Define RAM_ARRAY_FWD_EN for write-first reads on a same-address collision (read-first otherwise).
module ram_array_dp
    import ram_array_pkg::*;
#(
    parameter int                    DATA_WIDTH  = RAM_DATA_WIDTH,
    parameter int                    ADDR_WIDTH  = RAM_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] WADDR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic [ADDR_WIDTH-1:0] RADDR1,
    input  logic [ADDR_WIDTH-1:0] RADDR2,
    input  logic                  CLR,
    output logic [DATA_WIDTH-1:0] DATA_OUT1,
    output logic [DATA_WIDTH-1:0] DATA_OUT2,
    output logic                  BUSY
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;
    ram_state_e            state;
    logic                  ready;
    logic                  user_we;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk        (CLK),
        .rst_n      (RST_N),
        .clr        (CLR),
        .clear_we   (clear_we),
        .clear_addr (clear_addr),
        .busy       (BUSY),
        .state      (state)
    );

    // A clear request in the same cycle as a user write wins; the write is dropped.
    assign ready   = (state == READY);
    assign user_we = ready && WE && !CLR;
    assign wr_en   = clear_we || user_we;
    assign wr_addr = clear_we ? clear_addr : WADDR;
    assign wr_data = clear_we ? CLEAR_VALUE : DATA_IN;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Outputs read as zero whenever the sequencer owns, or is about to own, the array.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DATA_OUT1 <= '0;
            DATA_OUT2 <= '0;
        end else if (!ready || CLR) begin
            DATA_OUT1 <= '0;
            DATA_OUT2 <= '0;
        end else begin
`ifdef RAM_ARRAY_FWD_EN
            DATA_OUT1 <= (user_we && (RADDR1 == WADDR)) ? DATA_IN : mem[RADDR1];
            DATA_OUT2 <= (user_we && (RADDR2 == WADDR)) ? DATA_IN : mem[RADDR2];
`else
            DATA_OUT1 <= mem[RADDR1];
            DATA_OUT2 <= mem[RADDR2];
`endif
        end
    end

endmodule
